// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencer for the multiply-accumulate datapath.
// A start command issues a burst of operand reads. The block pulses the
// accumulator clear on the first read and drives the accumulator enable
// PIPE_LAT cycles behind the reads. It then holds the result valid until
// the consumer accepts it.
// Optional feature: define MAC_SEQ_ABORT_EN to add the abort_i port, which
// cancels a burst in flight. Without the macro the block behaves as if
// abort_i were tied low.
module mac_seq_ctrl #(
  parameter int WIDTH_CNT = 5,
  parameter int PIPE_LAT  = 2   // legal range 1..8
) (
  input  logic                 clk,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [WIDTH_CNT-1:0] len_i,
  output logic                 rd_en_o,
  output logic [WIDTH_CNT-1:0] rd_addr_o,
  output logic                 acc_clr_o,
  output logic                 acc_en_o,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic                 busy_o,
  output logic                 done_o
`ifdef MAC_SEQ_ABORT_EN
  ,
  input  logic                 abort_i
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  // The drain counter only has to reach PIPE_LAT-1, which is at most 7.
  localparam logic [3:0] DRAIN_LAST = 4'(PIPE_LAT - 1);

  state_t               state;
  logic [WIDTH_CNT-1:0] len_lat;
  logic [WIDTH_CNT-1:0] last_addr;
  logic [3:0]           drain_cnt;
  logic [PIPE_LAT-1:0]  acc_pipe;
  logic                 abort_req;

  // An abort only matters while a burst is in flight. In IDLE it is
  // ignored, so a start in the same cycle is still accepted.
`ifdef MAC_SEQ_ABORT_EN
  assign abort_req = abort_i && (state != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  // The address of the final read. len_lat is never zero while in ISSUE.
  assign last_addr = len_lat - WIDTH_CNT'(1);

  // Main FSM. All outputs except acc_en_o are registered here.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      len_lat     <= '0;
      rd_addr_o   <= '0;
      drain_cnt   <= '0;
      rd_en_o     <= 1'b0;
      acc_clr_o   <= 1'b0;
      res_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      // Both pulses last one cycle unless a transition below re-asserts them.
      acc_clr_o <= 1'b0;
      done_o    <= 1'b0;
      if (abort_req) begin
        state       <= IDLE;
        rd_addr_o   <= '0;
        drain_cnt   <= '0;
        rd_en_o     <= 1'b0;
        res_valid_o <= 1'b0;
        busy_o      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // A zero-length start is dropped. No burst is started for it.
            if (start_i && (len_i != '0)) begin
              state     <= ISSUE;
              len_lat   <= len_i;
              rd_addr_o <= '0;
              rd_en_o   <= 1'b1;
              acc_clr_o <= 1'b1;
              busy_o    <= 1'b1;
            end
          end
          ISSUE: begin
            // Stopping at len-1 means the counter never wraps, even for
            // the maximum length.
            if (rd_addr_o == last_addr) begin
              state     <= DRAIN;
              rd_addr_o <= '0;
              rd_en_o   <= 1'b0;
              drain_cnt <= '0;
            end else begin
              rd_addr_o <= rd_addr_o + WIDTH_CNT'(1);
            end
          end
          DRAIN: begin
            // Wait for the last operands to pass through the datapath pipeline.
            if (drain_cnt == DRAIN_LAST) begin
              state       <= OUT;
              res_valid_o <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + 4'd1;
            end
          end
          OUT: begin
            // Hold the result until the consumer takes it, then report completion.
            if (res_ready_i) begin
              state       <= IDLE;
              res_valid_o <= 1'b0;
              busy_o      <= 1'b0;
              done_o      <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // First stage of the enable delay line. It takes the registered read strobe.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_pipe[0] <= 1'b0;
    end else if (abort_req) begin
      acc_pipe[0] <= 1'b0;
    end else begin
      acc_pipe[0] <= rd_en_o;
    end
  end

  // Remaining delay stages. An abort flushes them, so no stale enables
  // reach the accumulator.
  generate
    for (genvar gi = 1; gi < PIPE_LAT; gi++) begin : g_acc_pipe
      // Shift one stage further down the delay line.
      always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
          acc_pipe[gi] <= 1'b0;
        end else if (abort_req) begin
          acc_pipe[gi] <= 1'b0;
        end else begin
          acc_pipe[gi] <= acc_pipe[gi-1];
        end
      end
    end
  endgenerate

  // The stage-0 register supplies one cycle of delay. The read strobe is
  // itself registered, so the total lag from the start is 1+PIPE_LAT cycles.
  assign acc_en_o = acc_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed testbench for mac_seq_ctrl (WIDTH_CNT=5, PIPE_LAT=2).
module tb_mac_seq_ctrl;
  localparam int W = 5;
  localparam int P = 2;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] len;
  logic         rd_en;
  logic [W-1:0] rd_addr;
  logic         acc_clr;
  logic         acc_en;
  logic         res_valid;
  logic         res_ready;
  logic         busy;
  logic         done;
  logic         abort;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mac_seq_ctrl #(.WIDTH_CNT(W), .PIPE_LAT(P)) dut (
    .clk         (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .len_i       (len),
    .rd_en_o     (rd_en),
    .rd_addr_o   (rd_addr),
    .acc_clr_o   (acc_clr),
    .acc_en_o    (acc_en),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .busy_o      (busy),
    .done_o      (done)
`ifdef MAC_SEQ_ABORT_EN
    ,
    .abort_i     (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".rd_en"},     32'(rd_en),     32'd0);
    chk({tag, ".rd_addr"},   32'(rd_addr),   32'd0);
    chk({tag, ".acc_clr"},   32'(acc_clr),   32'd0);
    chk({tag, ".acc_en"},    32'(acc_en),    32'd0);
    chk({tag, ".res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, ".busy"},      32'(busy),      32'd0);
    chk({tag, ".done"},      32'(done),      32'd0);
  endtask

  // The caller must be at the negedge of "cycle 0" with the DUT idle.
  // rdy:   first cycle in which res_ready is high.
  // stray: cycle with an extra start pulse (0 = none).
  // hold:  keep start high throughout and leave it high at the end.
  task automatic run_burst(input int l, input int rdy, input int stray, input bit hold);
    int h;
    h = (rdy > l + P + 1) ? rdy : l + P + 1;
    start = 1'b1;
    len   = W'(l);
    res_ready = (rdy <= 0);
    for (int c = 1; c <= h + 1; c++) begin
      @(negedge clk);
      cyc++;
      start     = hold || (c == stray);
      res_ready = (c >= rdy);
      chk("rd_en",     32'(rd_en),     32'((c >= 1) && (c <= l)));
      if ((c >= 1) && (c <= l))
        chk("rd_addr", 32'(rd_addr), 32'(c - 1));
      chk("acc_clr",   32'(acc_clr),   32'(c == 1));
      chk("acc_en",    32'(acc_en),    32'((c >= 1 + P) && (c <= l + P)));
      chk("res_valid", 32'(res_valid), 32'((c >= l + P + 1) && (c <= h)));
      chk("busy",      32'(busy),      32'(c <= h));
      chk("done",      32'(done),      32'(c == h + 1));
    end
    res_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    len   = '0;
    res_ready = 1'b0;
    abort = 1'b0;
    idle(2);
    all_zero("reset");
    rst_n = 1'b1;
    idle(2);
    all_zero("post_reset");

    // Basic burst: reads in cycles 1-4, acc_en in 3-6, valid in 7, done in 8.
    run_burst(4, 0, 0, 1'b0);
    idle(2);

    // Consumer stalls until cycle 12: valid in 7-12, done in 13.
    run_burst(4, 12, 0, 1'b0);
    idle(2);

    // A zero-length start is ignored.
    start = 1'b1;
    len   = '0;
    idle(1);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      all_zero("len0");
      idle(1);
    end

    // A stray start in cycle 2 of a 3-read burst is ignored.
    run_burst(3, 0, 2, 1'b0);
    idle(2);

    // Back-to-back single-read bursts with start held high.
    run_burst(1, 0, 0, 1'b1);
    run_burst(1, 0, 0, 1'b0);
    idle(2);

    // Maximum length: 31 reads with no wrap, valid in cycle 34.
    run_burst(31, 0, 0, 1'b0);
    idle(2);

    // Asynchronous reset in cycle 3 of an 8-read burst.
    start = 1'b1;
    len   = W'(8);
    idle(1);
    start = 1'b0;
    idle(2);
    chk("prereset.rd_en", 32'(rd_en), 32'd1);
    rst_n = 1'b0;
    #1;
    all_zero("midreset");
    idle(1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      all_zero("after_reset");
    end
    run_burst(2, 0, 0, 1'b0);
    idle(2);

`ifdef MAC_SEQ_ABORT_EN
    // Abort in cycle 5 of an 8-read burst: everything is zero from cycle 6, with no done.
    start = 1'b1;
    len   = W'(8);
    res_ready = 1'b1;
    idle(1);
    start = 1'b0;
    idle(4);
    chk("preabort.rd_en", 32'(rd_en), 32'd1);
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    for (int i = 0; i < 8; i++) begin
      all_zero("abort");
      idle(1);
    end
    res_ready = 1'b0;
    run_burst(2, 0, 0, 1'b0);
    idle(2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for the multiply-accumulate datapath: on a start command it issues a burst of operand reads, drives accumulator clear/enable aligned to the datapath pipeline latency, then holds the accumulated result valid until the consumer accepts it. It sits between the command interface and the operand buffers / MAC accumulator, and replaces ad-hoc counter control of the accumulator.

## Interface
- WIDTH_CNT, 5: width of burst length and read address.
- PIPE_LAT, 2: cycles from rd_en_o to operands at the accumulator input. Legal range is 1..8.

- clk  in  1  clock, all logic on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  start command, sampled only in IDLE.
- len_i  in  WIDTH_CNT  number of MAC operations, sampled with start_i.
- rd_en_o  out  1  operand read strobe.
- rd_addr_o  out  WIDTH_CNT  operand read address.
- acc_clr_o  out  1  accumulator clear, 1-cycle pulse.
- acc_en_o  out  1  accumulator enable.
- res_valid_o  out  1  accumulated result valid.
- res_ready_i  in  1  consumer accepts the result.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  1-cycle pulse after the result is accepted.
- abort_i  in  1  cancel the current burst. Present only with MAC_SEQ_ABORT_EN.

## Operation
- States are IDLE, ISSUE, DRAIN and OUT.
- IDLE:
  - start_i=1 with len_i!=0: latch len_i and go to ISSUE.
  - start_i=1 with len_i==0: ignored; stay in IDLE.
- ISSUE:
  - rd_en_o=1 every cycle.
  - rd_addr_o counts 0..len-1 from a WIDTH_CNT-bit issue counter.
  - acc_clr_o=1 in the first ISSUE cycle only.
  - The cycle with rd_addr_o==len-1 is the last ISSUE cycle; go to DRAIN.
- DRAIN:
  - Lasts exactly PIPE_LAT cycles, counted by a drain counter.
  - Then go to OUT.
- OUT:
  - res_valid_o=1 until res_valid_o&&res_ready_i.
  - On that handshake: go to IDLE and pulse done_o in the next cycle.
- acc_en_o is rd_en_o delayed by PIPE_LAT cycles through a shift register, cleared by reset.
- start_i in any non-IDLE state is ignored. No queueing.
- len_i=2^WIDTH_CNT-1 is legal. The issue counter never wraps within a burst.
- Arithmetic is unsigned. Counter increments are WIDTH_CNT bits wide.

## Timing
- Reset (asynchronous assert, synchronous deassert at the block boundary):
  - State is IDLE.
  - rd_en_o, rd_addr_o, acc_clr_o, acc_en_o, res_valid_o, busy_o and done_o are all 0.
  - The shift register is cleared.
- Take start accepted in cycle 0, length L:
  - Cycles 1..L: rd_en_o=1, rd_addr_o=cycle-1. acc_clr_o=1 in cycle 1.
  - Cycles 1+PIPE_LAT..L+PIPE_LAT: acc_en_o=1.
  - Cycles L+1..L+PIPE_LAT: DRAIN, busy_o=1.
  - Cycle L+PIPE_LAT+1 onward: res_valid_o=1.
- Handshake in cycle h:
  - Cycle h+1: done_o=1, busy_o=0, state IDLE.
  - A start_i in h+1 is accepted (back-to-back bursts).
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- Reset mid-burst: all outputs return to 0 immediately. The in-flight acc_en_o pipeline is discarded.

## Configuration
- MAC_SEQ_ABORT_EN defined:
  - abort_i port exists.
  - abort_i=1 in any non-IDLE state sends the block to IDLE in the next cycle.
  - From that cycle, rd_en_o, acc_en_o, res_valid_o and busy_o are 0, and the shift register is flushed.
  - done_o is not pulsed.
  - abort_i has priority over res_ready_i handshake.
  - abort_i in IDLE has no effect, and start_i in the same cycle is still accepted.
- MAC_SEQ_ABORT_EN undefined:
  - No abort_i port.
  - Behaviour is identical to abort_i tied to 0.

## Test plan
- PIPE_LAT=2, start with len_i=4 in cycle 0, res_ready_i=1 -> rd_en_o in cycles 1-4 with addr 0,1,2,3. acc_clr_o in cycle 1. acc_en_o in cycles 3-6. res_valid_o in cycle 7. done_o in cycle 8.
- Same burst with res_ready_i=0 until cycle 12 -> res_valid_o held in cycles 7-12. done_o in cycle 13 only.
- len_i=0 start; then start_i pulsed in cycle 2 of a len_i=3 burst -> both ignored: no rd_en_o for the len_i=0 start, exactly 3 reads for the len_i=3 burst, a single done_o.
- Back-to-back: start_i held high, len_i=1 -> second burst's rd_en_o in the cycle after done_o's cycle +1. Addresses restart at 0. acc_clr_o re-pulses.
- len_i=31 (WIDTH_CNT=5) -> 31 reads with addr 0..30, no wrap. res_valid_o in cycle 34.
- rst_n_i low in cycle 3 of a len_i=8 burst -> all outputs 0 asynchronously. After release, the block idles until a new start_i. With MAC_SEQ_ABORT_EN: abort_i in cycle 5 -> all outputs 0 from cycle 6, no done_o.
